// File: rtl/monitor_comparacao_pkg.sv
// Shared relation encodings and flag-decoding helpers for the comparator monitor.
// Imported by monitor_comparacao and contador_sat.
package monitor_comparacao_pkg;

  // Numeric order matches the up/down order ABAIXO < IGUAL < ACIMA.
  typedef enum logic [1:0] {
    ST_DESC   = 2'b00,
    ST_ABAIXO = 2'b01,
    ST_IGUAL  = 2'b10,
    ST_ACIMA  = 2'b11
  } estado_t;

  function automatic logic is_onehot(input logic [2:0] flags);
    return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  endfunction

  // flags = {aeqb, agtb, altb}; only meaningful when is_onehot(flags).
  function automatic estado_t flags_to_rel(input logic [2:0] flags);
    estado_t rel;
    rel = ST_DESC;
    if (flags[2])      rel = ST_IGUAL;
    else if (flags[1]) rel = ST_ACIMA;
    else if (flags[0]) rel = ST_ABAIXO;
    return rel;
  endfunction

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter used for the crossing count; holds at all-ones.
module contador_sat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset)                  r_q <= '0;
    else if (inc && (r_q != '1)) r_q <= r_q + 1'b1;
  end

  assign q = r_q;

endmodule

// File: rtl/monitor_comparacao.sv
// Debounced relation tracker for the registered aeqb/agtb/altb comparator flags.
// Define MONCMP_CROSS_CNT_EN to build the saturating crossing counter on cruz_cnt.
module monitor_comparacao
  import monitor_comparacao_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             aeqb,
  input  logic             agtb,
  input  logic             altb,
  input  logic             erro_clr,
  output logic [1:0]       estado,
  output logic             evt_sobe,
  output logic             evt_desce,
  output logic             erro,
  output logic [CNT_W-1:0] cruz_cnt
);

  localparam int RUN_W = $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(DEBOUNCE);

  estado_t          r_estado, r_cand;
  logic [RUN_W-1:0] r_run;
  logic             r_erro, r_sobe, r_desce;

  logic [2:0]       w_flags;
  logic             w_legal;
  estado_t          w_rel;
  logic [RUN_W-1:0] w_nrun;
  estado_t          w_estado_nxt, w_cand_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_erro_nxt, w_sobe_nxt, w_desce_nxt;

  assign w_flags = {aeqb, agtb, altb};
  assign w_legal = is_onehot(w_flags);
  assign w_rel   = flags_to_rel(w_flags);
  assign w_nrun  = (w_rel == r_cand) ? r_run + 1'b1 : RUN_W'(1);

  // NOTE: every signal written here gets its default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_estado_nxt = r_estado;
    w_cand_nxt   = r_cand;
    w_run_nxt    = r_run;
    w_erro_nxt   = r_erro & ~erro_clr;
    w_sobe_nxt   = 1'b0;
    w_desce_nxt  = 1'b0;

    if (in_valid) begin
      if (!w_legal) begin
        w_erro_nxt = 1'b1;
        w_cand_nxt = ST_DESC;
        w_run_nxt  = '0;
      end else if (w_rel == r_estado) begin
        w_cand_nxt = w_rel;
        w_run_nxt  = '0;
      end else begin
        w_cand_nxt = w_rel;
        if (w_nrun == RUN_TARGET) begin
          w_estado_nxt = w_rel;
          w_run_nxt    = '0;
          // Leaving DESC is an initial lock, not a crossing.
          if (r_estado != ST_DESC) begin
            w_sobe_nxt  = (w_rel > r_estado);
            w_desce_nxt = (w_rel < r_estado);
          end
        end else begin
          w_run_nxt = w_nrun;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= ST_DESC;
      r_cand   <= ST_DESC;
      r_run    <= '0;
      r_erro   <= 1'b0;
      r_sobe   <= 1'b0;
      r_desce  <= 1'b0;
    end else begin
      r_estado <= w_estado_nxt;
      r_cand   <= w_cand_nxt;
      r_run    <= w_run_nxt;
      r_erro   <= w_erro_nxt;
      r_sobe   <= w_sobe_nxt;
      r_desce  <= w_desce_nxt;
    end
  end

  assign estado    = r_estado;
  assign evt_sobe  = r_sobe;
  assign evt_desce = r_desce;
  assign erro      = r_erro;

`ifdef MONCMP_CROSS_CNT_EN
  // Counts on the commit edge, so cruz_cnt steps together with the event pulse.
  contador_sat #(.W(CNT_W)) u_cruz_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_sobe_nxt | w_desce_nxt),
    .q     (cruz_cnt)
  );
`else
  assign cruz_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_monitor_comparacao.sv
// Scoreboard bench for monitor_comparacao: directed scenarios plus randomized runs
// checked against a sample-history reference model.
module tb_monitor_comparacao;

  localparam int DEB   = 3;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             aeqb = 1'b0, agtb = 1'b0, altb = 1'b0;
  logic             erro_clr = 1'b0;
  logic [1:0]       estado;
  logic             evt_sobe, evt_desce, erro;
  logic [CNT_W-1:0] cruz_cnt;

  monitor_comparacao #(.DEBOUNCE(DEB), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .aeqb      (aeqb),
    .agtb      (agtb),
    .altb      (altb),
    .erro_clr  (erro_clr),
    .estado    (estado),
    .evt_sobe  (evt_sobe),
    .evt_desce (evt_desce),
    .erro      (erro),
    .cruz_cnt  (cruz_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       estado;
    logic             up;
    logic             down;
    logic             erro;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: relation 0 DESC, 1 a<b, 2 a==b, 3 a>b; hist holds the recent
  // legal samples that differ from the confirmed relation.
  int m_est  = 0;
  int hist[$];
  bit m_erro = 1'b0;
  int m_cnt  = 0;

  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  task automatic model(input bit rst, input bit v, input logic [2:0] f, input bit clr);
    exp_t e;
    int   r;
    bit   all_same;
    e.up   = 1'b0;
    e.down = 1'b0;
    if (rst) begin
      m_est = 0; hist.delete(); m_erro = 1'b0; m_cnt = 0;
    end else begin
      if (clr) m_erro = 1'b0;
      if (v) begin
        if ($countones(f) != 1) begin
          m_erro = 1'b1;
          hist.delete();
        end else begin
          r = f[2] ? 2 : (f[1] ? 3 : 1);
          if (r == m_est) hist.delete();
          else begin
            hist.push_back(r);
            if (hist.size() > DEB) void'(hist.pop_front());
            all_same = (hist.size() == DEB);
            foreach (hist[k]) if (hist[k] != r) all_same = 1'b0;
            if (all_same) begin
              if (m_est != 0) begin
                e.up   = (r > m_est);
                e.down = (r < m_est);
                if (m_cnt < CMAX) m_cnt++;
              end
              m_est = r;
              hist.delete();
            end
          end
        end
      end
    end
    e.estado = 2'(m_est);
    e.erro   = m_erro;
`ifdef MONCMP_CROSS_CNT_EN
    e.cnt = CNT_W'(m_cnt);
`else
    e.cnt = '0;
`endif
    sb.push_back(e);
  endtask

  task automatic apply(input bit rst, input bit v, input logic [2:0] f, input bit clr);
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    {aeqb, agtb, altb} = f;
    erro_clr = clr;
    model(rst, v, f, clr);
  endtask

  task automatic sample(input logic [2:0] f, input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b1, f, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: every edge produces an output vector, compared against the queued model value.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (estado !== e.estado || evt_sobe !== e.up || evt_desce !== e.down ||
            erro !== e.erro || cruz_cnt !== e.cnt) begin
          n_err++;
          $display("FAIL vec@%0t: estado=%0d/%0d sobe=%0b/%0b desce=%0b/%0b erro=%0b/%0b cnt=%0d/%0d (got/exp)",
                   $time, estado, e.estado, evt_sobe, e.up, evt_desce, e.down,
                   erro, e.erro, cruz_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [2:0] f;
    int         len;
    int         waited;

    apply(1'b1, 1'b0, 3'b000, 1'b0);
    apply(1'b1, 1'b0, 3'b000, 1'b0);

    sample(F_EQ, DEB); settle();
    check("t1_estado", estado, 2);
    check("t1_no_evt", evt_sobe | evt_desce, 0);
    check("t1_cnt", cruz_cnt, 0);

    sample(F_GT, DEB); settle();
    check("t2_estado", estado, 3);
    check("t2_sobe", evt_sobe, 1);

    sample(F_LT, 2); sample(F_GT, 1); sample(F_LT, 2); settle();
    check("t3_hold", estado, 3);
    sample(F_LT, 1); settle();
    check("t3_estado", estado, 1);
    check("t3_desce", evt_desce, 1);

    apply(1'b0, 1'b1, 3'b011, 1'b0); settle();
    check("t4_erro_set", erro, 1);
    check("t4_estado_held", estado, 1);
    apply(1'b0, 1'b0, 3'b000, 1'b1); settle();
    check("t4_erro_clr", erro, 0);
    apply(1'b0, 1'b1, 3'b000, 1'b1); settle();
    check("t4_set_wins", erro, 1);

    sample(F_GT, DEB);
    sample(F_LT, 2); idle(4); sample(F_LT, 1); settle();
    check("t5_gap_commit", estado, 1);

    sample(F_GT, DEB);
    apply(1'b1, 1'b0, 3'b000, 1'b0); settle();
    check("t6_rst_estado", estado, 0);
    check("t6_rst_evt", evt_sobe | evt_desce, 0);
    apply(1'b0, 1'b0, 3'b000, 1'b0);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0:       f = 3'($urandom_range(0, 7));
        1, 2, 3: f = F_LT;
        4, 5, 6: f = F_GT;
        default: f = F_EQ;
      endcase
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++)
        apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0), f,
              ($urandom_range(0, 29) == 0));
    end

    apply(1'b1, 1'b0, 3'b000, 1'b0);
    sample(F_EQ, DEB);
    for (int i = 0; i < CMAX + 3; i++) sample((i % 2 == 0) ? F_GT : F_LT, DEB);
    settle();
`ifdef MONCMP_CROSS_CNT_EN
    check("sat_cnt", cruz_cnt, CMAX);
`else
    check("sat_cnt_tied", cruz_cnt, 0);
`endif

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
